truth_table_capture: RTL

// Response-side partner of the 5-input combinational stimulus sweeps (A..E -> Y).
// - Accepts each applied input vector and the DUT output Y.
// - Waits a settle interval, then samples Y into a 2**NIN-entry truth table.
// - Compares each sample against an expected minterm mask and tracks coverage and errors.
// - Flags completion once every input combination has been seen.

---
 rtl/truth_table_capture_if.sv | 13 +
 rtl/truth_table_capture.sv | 127 ++++++++++++
 2 files changed

// File: rtl/truth_table_capture_if.sv
// Vector handshake between a stimulus sweeper and the truth-table capture block.
`timescale 1ns/1ps
interface truth_table_capture_if #(
  parameter int NIN = 5
);
  logic           vec_valid;
  logic           vec_ready;
  logic [NIN-1:0] vec;
  logic           y;

  modport master (output vec_valid, output vec, output y, input vec_ready);
  modport slave  (input vec_valid, input vec, input y, output vec_ready);
endinterface

// File: rtl/truth_table_capture.sv
// Captures a combinational DUT output per input vector into a truth table,
// checking each sample against an expected minterm mask.
`timescale 1ns/1ps
module truth_table_capture #(
  parameter int                  NIN        = 5,
  parameter int                  SETTLE_CYC = 2,
  parameter logic [(2**NIN)-1:0] EXP_MASK   = {(2**NIN){1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  truth_table_capture_if.slave   bus,
  output logic [(2**NIN)-1:0]    table_out,
  output logic [(2**NIN)-1:0]    covered,
  output logic [NIN:0]           err_cnt,
  output logic                   err_flag,
  output logic [NIN-1:0]         first_err,
  output logic                   done
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [NIN-1:0] idx_r;
  logic [CW-1:0]  cnt_r;
  logic           mismatch_s;

  // FSM state register; clear overrides any pending transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else if (clear) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.vec_valid) begin
          state_s = ST_SETTLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_s = ST_SAMPLE;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_SAMPLE: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: only IDLE accepts a new vector
  always_comb begin
    bus.vec_ready = 1'b0;
    case (state_r)
      ST_IDLE:   bus.vec_ready = 1'b1;
      ST_SETTLE: bus.vec_ready = 1'b0;
      ST_SAMPLE: bus.vec_ready = 1'b0;
      default:   bus.vec_ready = 1'b0;
    endcase
  end

  // Latch the vector index at accept and count down the settle interval
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= {NIN{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      idx_r <= {NIN{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if ((state_r == ST_IDLE) && bus.vec_valid) begin
      idx_r <= bus.vec;
      cnt_r <= CW'(SETTLE_CYC - 1);
    end else if ((state_r == ST_SETTLE) && (cnt_r != {CW{1'b0}})) begin
      cnt_r <= cnt_r - CW'(1);
    end
  end

  assign mismatch_s = (bus.y != EXP_MASK[idx_r]);

  // Table, coverage and error bookkeeping, updated only in the SAMPLE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      table_out <= {(2**NIN){1'b0}};
      covered   <= {(2**NIN){1'b0}};
      err_cnt   <= {(NIN+1){1'b0}};
      err_flag  <= 1'b0;
      first_err <= {NIN{1'b0}};
    end else if (clear) begin
      table_out <= {(2**NIN){1'b0}};
      covered   <= {(2**NIN){1'b0}};
      err_cnt   <= {(NIN+1){1'b0}};
      err_flag  <= 1'b0;
      first_err <= {NIN{1'b0}};
    end else if (state_r == ST_SAMPLE) begin
      table_out[idx_r] <= bus.y;
      covered[idx_r]   <= 1'b1;
      if (mismatch_s && (err_cnt != {(NIN+1){1'b1}})) begin
        err_cnt <= err_cnt + (NIN+1)'(1);
      end
      if (mismatch_s && !err_flag) begin
        err_flag  <= 1'b1;
        first_err <= idx_r;
      end
    end
  end

  assign done = &covered;

endmodule
